// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage.
// Covers the size encodings and the byte-lane store and load helpers.
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Size 2'b11 falls into the word branch everywhere.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{data[7:0]}};
      SZ_HALF: lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled synchronous-read data RAM, read-first, with a held read register.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Byte-lane writes; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register samples the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: data RAM, misalign detection, MEM/WB register.
// The write-back bus doubles as the forwarding source for earlier stages.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,  // byte-lane logic is fixed at 32 bits
  parameter int DEPTH  = 256,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid_in,
  input  logic              Stall_in,
  input  logic              Flush_in,
  input  logic              Ctl_MemtoReg_in,
  input  logic              Ctl_MemWrite_in,
  input  logic              Ctl_MemRead_in,
  input  logic              Ctl_RegWrite_in,
  input  logic [1:0]        Size_in,
  input  logic              Unsigned_in,
  input  logic [REG_W-1:0]  Rd_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] Write_Data_in,
  output logic              WB_valid,
  output logic              WB_RegWrite,
  output logic [REG_W-1:0]  WB_Rd,
  output logic [DATA_W-1:0] WriteData_out,
  output logic              Misalign_out
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     word_idx_s;
  logic [1:0]        off_s;
  logic              mis_s;
  logic              wr_fire_s;
  logic [3:0]        we_s;
  logic [31:0]       wdata_s;
  logic [31:0]       rdata_s;

  logic              valid_r;
  logic              memtoreg_r;
  logic              regwrite_r;
  logic              uns_r;
  logic              mis_r;
  logic [1:0]        size_r;
  logic [1:0]        off_r;
  logic [REG_W-1:0]  rd_r;
  logic [DATA_W-1:0] alu_r;

  assign word_idx_s = ALUresult_in[AW+1:2];
  assign off_s      = ALUresult_in[1:0];

  // Misalignment only matters for instructions that touch memory.
  always_comb begin
    mis_s = 1'b0;
    if (Ctl_MemRead_in || Ctl_MemWrite_in) begin
      case (Size_in)
        SZ_BYTE: mis_s = 1'b0;
        SZ_HALF: mis_s = off_s[0];
        default: mis_s = (off_s != 2'b00);
      endcase
    end else begin
      mis_s = 1'b0;
    end
  end

  // Reset level also gates the write so nothing lands in memory while held in reset.
  assign wr_fire_s = rst & Valid_in & Ctl_MemWrite_in & ~Stall_in & ~Flush_in & ~mis_s;
  assign we_s      = wr_fire_s ? byte_en(Size_in, off_s) : 4'b0000;
  assign wdata_s   = store_lanes(Size_in, Write_Data_in);

  dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .re    (~Stall_in),
    .we    (we_s),
    .addr  (word_idx_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // MEM/WB boundary register: flush beats stall, stall freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r    <= 1'b0;
      memtoreg_r <= 1'b0;
      regwrite_r <= 1'b0;
      uns_r      <= 1'b0;
      mis_r      <= 1'b0;
      size_r     <= 2'b00;
      off_r      <= 2'b00;
      rd_r       <= '0;
      alu_r      <= '0;
    end else if (Flush_in) begin
      valid_r    <= 1'b0;
    end else if (!Stall_in) begin
      valid_r    <= Valid_in;
      memtoreg_r <= Ctl_MemtoReg_in;
      regwrite_r <= Ctl_RegWrite_in;
      uns_r      <= Unsigned_in;
      mis_r      <= mis_s;
      size_r     <= Size_in;
      off_r      <= off_s;
      rd_r       <= Rd_in;
      alu_r      <= ALUresult_in;
    end
  end

  assign WB_valid      = valid_r;
  assign WB_RegWrite   = valid_r & regwrite_r & ~mis_r;
  assign WB_Rd         = rd_r;
  assign Misalign_out  = valid_r & mis_r;
  assign WriteData_out = memtoreg_r ? load_align(rdata_s, size_r, off_r, uns_r) : alu_r;

endmodule
